// File: rtl/bank_sel_arb_pkg.sv
// -----------------------------------------------------------------------------
// bank_sel_arb_pkg
// Shared definitions for the bank select arbiter:
//   NUM_REQ / IDX_W  : requester count and index width
//   arb_state_e      : arbiter FSM states
//   pick_t, rr_pick  : rotating-priority pick (winning index plus found flag)
// -----------------------------------------------------------------------------
package bank_sel_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Search eligible starting at ptr and moving upward mod NUM_REQ. The loop
  // runs from the farthest offset down to offset 0, so the closest set bit to
  // ptr is the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] eligible,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t            res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (eligible[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bank_sel_arbiter_if.sv
// -----------------------------------------------------------------------------
// bank_sel_arbiter_if
// Request/grant bundle between the access engines and the arbiter.
//   req        : per-requester level request (driven by requesters)
//   gnt        : one-hot registered grant
//   gnt_valid  : any grant active
//   gnt_idx    : binary index of current/last owner
//   bank_sel_n : active-low one-hot bank select
//   timeout    : one-cycle pulse on a forced revoke
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface bank_sel_arbiter_if;
  import bank_sel_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] bank_sel_n;
  logic               timeout;

  modport master (
    output req,
    input  gnt, gnt_valid, gnt_idx, bank_sel_n, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_valid, gnt_idx, bank_sel_n, timeout
  );
endinterface

// File: rtl/bank_sel_decode.sv
// -----------------------------------------------------------------------------
// bank_sel_decode
// Turns a registered owner index plus valid into the active-low one-hot bank
// select; all ones when no owner is valid.
//   idx_i    : registered owner index
//   valid_i  : registered "grant active"
//   sel_n_o  : active-low one-hot select
// -----------------------------------------------------------------------------
module bank_sel_decode
  import bank_sel_arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               valid_i,
  output logic [NUM_REQ-1:0] sel_n_o
);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
    assign sel_n_o[gi] = ~(valid_i && (idx_i == IDX_W'(gi)));
  end

endmodule

// File: rtl/bank_sel_arbiter.sv
// -----------------------------------------------------------------------------
// bank_sel_arbiter
// Round-robin owner of a single 4-way bank select with break-before-make: every
// ownership change passes through one all-deselected RELEASE cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : bank_sel_arbiter_if.slave (req in; gnt, gnt_valid, gnt_idx,
//          bank_sel_n, timeout out)
// Parameter HOLD_MAX: grant hold limit (1..255), only meaningful when the
// optional timeout is compiled in with BANK_SEL_ARB_TIMEOUT_EN. Without it a
// grant is held until the owner drops req, and timeout is tied low.
// -----------------------------------------------------------------------------
module bank_sel_arbiter
  import bank_sel_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  bank_sel_arbiter_if.slave   bus
);

  if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_hold_max_range
    $error("bank_sel_arbiter: HOLD_MAX must be within 1..255");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] mask_q;
  pick_t              pick;

`ifdef BANK_SEL_ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0] mask_d;
  logic [7:0]         hold_q, hold_d;
  logic               timeout_q, timeout_d;
`else
  assign mask_q = '0;
`endif

  assign pick = rr_pick(bus.req & ~mask_q, ptr_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef BANK_SEL_ARB_TIMEOUT_EN
    // A masked offender is released from the mask once its req is seen low.
    mask_d    = mask_q & bus.req;
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE, RELEASE: begin
        gnt_d = '0;
        if (pick.found) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << pick.idx;
          idx_d   = pick.idx;
`ifdef BANK_SEL_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[idx_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
          ptr_d   = idx_q + IDX_W'(1);
`ifdef BANK_SEL_ARB_TIMEOUT_EN
        end else if (hold_q == 8'(HOLD_MAX - 1)) begin
          // hold_q counts from 0 in the first grant cycle, so this edge ends
          // the HOLD_MAX-th cycle of ownership.
          state_d       = RELEASE;
          gnt_d         = '0;
          ptr_d         = idx_q + IDX_W'(1);
          timeout_d     = 1'b1;
          mask_d[idx_q] = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef BANK_SEL_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q    <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_idx   = idx_q;

  bank_sel_decode u_decode (
    .idx_i   (idx_q),
    .valid_i (|gnt_q),
    .sel_n_o (bus.bank_sel_n)
  );

endmodule

// File: tb/tb_bank_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bank_sel_arbiter
// Drives request patterns cycle by cycle; the expected grant/index/timeout for
// each cycle is queued as the stimulus is applied and compared once the DUT
// has clocked it in. Timeout scenario is exercised when
// BANK_SEL_ARB_TIMEOUT_EN is defined (HOLD_MAX=4), indefinite hold otherwise.
// -----------------------------------------------------------------------------
module tb_bank_sel_arbiter;

  logic clk;
  logic rst;

  bank_sel_arbiter_if bus_if ();

  bank_sel_arbiter #(.HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive req for one cycle; queue what the DUT must show after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg,
                      input logic [1:0] ei, input logic et);
    exp_t       e;
    exp_t       got_e;
    logic [3:0] sel_exp;
    bus_if.req = r;
    e.gnt = eg;
    e.idx = ei;
    e.to  = et;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_e   = sb_q.pop_front();
    sel_exp = ~got_e.gnt;
    n_txn++;
    $display("txn %0d: req=%b gnt=%b idx=%0d sel_n=%b to=%b (exp gnt=%b idx=%0d to=%b)",
             n_txn, r, bus_if.gnt, bus_if.gnt_idx, bus_if.bank_sel_n, bus_if.timeout,
             got_e.gnt, got_e.idx, got_e.to);
    chk("gnt",        32'(bus_if.gnt),        32'(got_e.gnt));
    chk("gnt_idx",    32'(bus_if.gnt_idx),    32'(got_e.idx));
    chk("gnt_valid",  32'(bus_if.gnt_valid),  32'(|got_e.gnt));
    chk("bank_sel_n", 32'(bus_if.bank_sel_n), 32'(sel_exp));
    chk("timeout",    32'(bus_if.timeout),    32'(got_e.to));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bank_sel_n"}, 32'(bus_if.bank_sel_n), 32'hF);
    chk({tag, "_gnt"},        32'(bus_if.gnt),        32'h0);
    chk({tag, "_gnt_valid"},  32'(bus_if.gnt_valid),  32'h0);
    chk({tag, "_gnt_idx"},    32'(bus_if.gnt_idx),    32'h0);
    chk({tag, "_timeout"},    32'(bus_if.timeout),    32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    bus_if.req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");
    rst = 1'b0;

    // Reset release with all requesting: requester 0 first.
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Single request from idle, then drop: one dead cycle, idx holds.
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);

    // Wrap: grant 3, release, then 1001 picks 0 (pointer wrapped to 0).
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);
    step(4'b1001, 4'b0001, 2'd0, 1'b0);
    step(4'b1001, 4'b0001, 2'd0, 1'b0);
    step(4'b1000, 4'b0000, 2'd0, 1'b0);
    // Pointer is now 1: with 1001 requesting, 3 wins over 0.
    step(4'b1001, 4'b1000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);

    // Round robin with all requesting, each owner drops after 2 cycles.
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1110, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b0);
    step(4'b1101, 4'b0000, 2'd1, 1'b0);
    step(4'b1111, 4'b0100, 2'd2, 1'b0);
    step(4'b1111, 4'b0100, 2'd2, 1'b0);
    step(4'b1011, 4'b0000, 2'd2, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b0);
    step(4'b0111, 4'b0000, 2'd3, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Pointer is 1: requester 1 wins with 2 also requesting.
`ifdef BANK_SEL_ARB_TIMEOUT_EN
    repeat (4) step(4'b0110, 4'b0010, 2'd1, 1'b0);
    step(4'b0110, 4'b0000, 2'd1, 1'b1);
    step(4'b0110, 4'b0100, 2'd2, 1'b0);
    step(4'b0110, 4'b0100, 2'd2, 1'b0);
    step(4'b0010, 4'b0000, 2'd2, 1'b0);
    // Requester 1 still masked while its req stays high.
    step(4'b0010, 4'b0000, 2'd2, 1'b0);
    step(4'b0010, 4'b0000, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);
    step(4'b0010, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
`else
    repeat (20) step(4'b0110, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
`endif

    // Pointer is 2: grant 3, then async reset in the middle of ownership.
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    chk_reset_outputs("held_rst");
    rst = 1'b0;
    // Pointer back at 0: 1 wins over 3.
    step(4'b1010, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
